// File: rtl/timer_pkg.sv
// Shared types and helpers for the tick timer scheduler: channel state encoding,
// default clock rate and the prescaler divide-ratio derivation.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } ch_state_t;

    localparam int DEFAULT_CLK_HZ = 100_000_000;

    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/tick_timer_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set bit of req at or after ptr,
// wrapping around to index 0.
module rr_arbiter
    import timer_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] grant,
    output logic                 any
);

    localparam int W = $clog2(N);

    // Two passes: upper segment [ptr..N-1] has priority over the wrapped [0..ptr-1].
    always_comb begin
        grant = W'(0);
        any   = 1'b0;
        for (int c = 0; c < N; c++) begin
            if (!any && req[c] && (c >= int'(ptr))) begin
                any   = 1'b1;
                grant = W'(c);
            end else begin
                any   = any;
            end
        end
        for (int c = 0; c < N; c++) begin
            if (!any && req[c] && (c < int'(ptr))) begin
                any   = 1'b1;
                grant = W'(c);
            end else begin
                any   = any;
            end
        end
    end

endmodule

// File: rtl/tick_timer_scheduler.sv
// Multi-channel tick-based countdown timers sharing one prescaler, with expiry
// events serialized through a round-robin valid/ready port. Optional macro: TIMER_PAUSE_EN.
module tick_timer_scheduler
    import timer_pkg::*;
#(
    parameter int CLK_HZ  = DEFAULT_CLK_HZ,
    parameter int TICK_HZ = 1,
    parameter int NCH     = 4,
    parameter int DUR_W   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NCH-1:0]         start,
    input  logic [NCH*DUR_W-1:0]   dur,
    input  logic [NCH-1:0]         cancel,
`ifdef TIMER_PAUSE_EN
    input  logic                   pause,
`endif
    output logic [NCH-1:0]         busy,
    output logic [NCH*DUR_W-1:0]   remain,
    output logic                   tick,
    output logic                   evt_valid,
    output logic [$clog2(NCH)-1:0] evt_ch,
    input  logic                   evt_ready
);

    localparam int DIV   = calc_div(CLK_HZ, TICK_HZ);
    localparam int CNT_W = $clog2(DIV);
    localparam int CH_W  = $clog2(NCH);

    logic [CNT_W-1:0] cnt_r;
    logic             pause_s;
    logic             wrap_s;
    logic             tick_s;

    ch_state_t        state_r      [NCH];
    ch_state_t        state_nxt_s  [NCH];
    logic [DUR_W-1:0] remain_r     [NCH];
    logic [DUR_W-1:0] remain_nxt_s [NCH];
    logic [NCH-1:0]   busy_r;
    logic [NCH-1:0]   req_s;

    logic             evt_valid_r;
    logic [CH_W-1:0]  evt_ch_r;
    logic [CH_W-1:0]  ptr_r;
    logic [CH_W-1:0]  nxt_ptr_s;
    logic [CH_W-1:0]  arb_ptr_s;
    logic [CH_W-1:0]  grant_s;
    logic             any_s;
    logic             hs_s;

`ifdef TIMER_PAUSE_EN
    assign pause_s = pause;
`else
    assign pause_s = 1'b0;
`endif

    // Tick decode: pause masks the tick immediately, not just the count.
    always_comb begin
        wrap_s = (cnt_r == CNT_W'(DIV - 1));
        if (pause_s) begin
            tick_s = 1'b0;
        end else begin
            tick_s = wrap_s;
        end
    end

    // Prescaler counter, held while paused.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= CNT_W'(0);
        end else if (pause_s) begin
            cnt_r <= cnt_r;
        end else if (wrap_s) begin
            cnt_r <= CNT_W'(0);
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign hs_s = evt_valid_r & evt_ready;

    // Per-channel next state; the presented channel is locked until its handshake.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_nxt_s[i]  = state_r[i];
            remain_nxt_s[i] = remain_r[i];
            req_s[i]        = 1'b0;
            if (evt_valid_r && (evt_ch_r == CH_W'(i))) begin
                if (evt_ready) begin
                    state_nxt_s[i]  = IDLE;
                    remain_nxt_s[i] = DUR_W'(0);
                end else begin
                    state_nxt_s[i]  = state_r[i];
                end
            end else begin
                // A channel being cancelled this cycle must not win arbitration.
                req_s[i] = (state_r[i] == PEND) && !cancel[i];
                case (state_r[i])
                    IDLE: begin
                        if (start[i] && !cancel[i]) begin
                            remain_nxt_s[i] = dur[i*DUR_W +: DUR_W];
                            state_nxt_s[i]  = (dur[i*DUR_W +: DUR_W] == DUR_W'(0)) ? PEND : RUN;
                        end else begin
                            state_nxt_s[i]  = IDLE;
                        end
                    end
                    RUN: begin
                        if (cancel[i]) begin
                            state_nxt_s[i]  = IDLE;
                            remain_nxt_s[i] = DUR_W'(0);
                        end else if (start[i]) begin
                            remain_nxt_s[i] = dur[i*DUR_W +: DUR_W];
                            state_nxt_s[i]  = (dur[i*DUR_W +: DUR_W] == DUR_W'(0)) ? PEND : RUN;
                        end else if (tick_s) begin
                            if (remain_r[i] <= DUR_W'(1)) begin
                                remain_nxt_s[i] = DUR_W'(0);
                                state_nxt_s[i]  = PEND;
                            end else begin
                                remain_nxt_s[i] = remain_r[i] - DUR_W'(1);
                            end
                        end else begin
                            state_nxt_s[i]  = RUN;
                        end
                    end
                    PEND: begin
                        if (cancel[i]) begin
                            state_nxt_s[i]  = IDLE;
                            remain_nxt_s[i] = DUR_W'(0);
                        end else begin
                            state_nxt_s[i]  = PEND;
                        end
                    end
                    default: begin
                        state_nxt_s[i]  = IDLE;
                        remain_nxt_s[i] = DUR_W'(0);
                    end
                endcase
            end
        end
    end

    // Channel state, remaining count and busy flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                state_r[i]  <= IDLE;
                remain_r[i] <= DUR_W'(0);
            end
            busy_r <= NCH'(0);
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_r[i]  <= state_nxt_s[i];
                remain_r[i] <= remain_nxt_s[i];
                busy_r[i]   <= (state_nxt_s[i] != IDLE);
            end
        end
    end

    // On a handshake the search already starts past the channel just retired.
    always_comb begin
        if (evt_ch_r == CH_W'(NCH - 1)) begin
            nxt_ptr_s = CH_W'(0);
        end else begin
            nxt_ptr_s = evt_ch_r + CH_W'(1);
        end
        if (hs_s) begin
            arb_ptr_s = nxt_ptr_s;
        end else begin
            arb_ptr_s = ptr_r;
        end
    end

    rr_arbiter #(
        .N (NCH)
    ) u_arb (
        .req   (req_s),
        .ptr   (arb_ptr_s),
        .grant (grant_s),
        .any   (any_s)
    );

    // Event output register and round-robin pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evt_valid_r <= 1'b0;
            evt_ch_r    <= CH_W'(0);
            ptr_r       <= CH_W'(0);
        end else begin
            if (hs_s) begin
                ptr_r <= nxt_ptr_s;
            end else begin
                ptr_r <= ptr_r;
            end
            if (!evt_valid_r || hs_s) begin
                evt_valid_r <= any_s;
                if (any_s) begin
                    evt_ch_r <= grant_s;
                end else begin
                    evt_ch_r <= evt_ch_r;
                end
            end else begin
                evt_valid_r <= evt_valid_r;
            end
        end
    end

    // Output packing.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            remain[i*DUR_W +: DUR_W] = remain_r[i];
        end
    end

    assign busy      = busy_r;
    assign tick      = tick_s;
    assign evt_valid = evt_valid_r;
    assign evt_ch    = evt_ch_r;

endmodule

// File: tb/tb_tick_timer_scheduler.sv
// Scoreboard bench for tick_timer_scheduler (DIV=10, NCH=4, DUR_W=8); expected
// events are queued by the stimulus and retired by a monitor on each handshake.
module tb_tick_timer_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  start = 4'd0;
    logic [3:0]  cancel = 4'd0;
    logic [31:0] dur = 32'd0;
    logic        pause = 1'b0;
    logic [3:0]  busy;
    logic [31:0] remain;
    logic        tick;
    logic        evt_valid;
    logic [1:0]  evt_ch;
    logic        evt_ready = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];
    int mcnt;

    logic       prev_valid;
    logic       prev_ready;
    logic [1:0] prev_ch;

    always #5 clk = ~clk;

    tick_timer_scheduler #(
        .CLK_HZ  (10),
        .TICK_HZ (1),
        .NCH     (4),
        .DUR_W   (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dur       (dur),
        .cancel    (cancel),
`ifdef TIMER_PAUSE_EN
        .pause     (pause),
`endif
        .busy      (busy),
        .remain    (remain),
        .tick      (tick),
        .evt_valid (evt_valid),
        .evt_ch    (evt_ch),
        .evt_ready (evt_ready)
    );

    // Reference prescaler: 0..9, held while paused.
    always @(posedge clk or posedge reset) begin
        if (reset) mcnt <= 0;
        else if (!pause) mcnt <= (mcnt == 9) ? 0 : mcnt + 1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: event stability while stalled, and in-order retirement on handshake.
    always @(negedge clk) begin
        if (reset) begin
            prev_valid <= 1'b0;
            prev_ready <= 1'b0;
            prev_ch    <= 2'd0;
        end else begin
            if (prev_valid && !prev_ready) begin
                chk("evt_hold_valid", int'(evt_valid), 1);
                chk("evt_hold_ch", int'(evt_ch), int'(prev_ch));
            end
            if (evt_valid && evt_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL evt_unexpected: got ch %0d expected no event", evt_ch);
                end else begin
                    chk("evt_ch_order", int'(evt_ch), exp_q.pop_front());
                end
            end
            prev_valid <= evt_valid;
            prev_ready <= evt_ready;
            prev_ch    <= evt_ch;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int rem(input int i);
        return int'(remain[i*8 +: 8]);
    endfunction

    task automatic set_dur(input int i, input int v);
        dur[i*8 +: 8] = 8'(v);
    endtask

    // Advance until tick is seen, then through the tick edge itself.
    task automatic wait_tick_edge(input string nm);
        int k = 0;
        while (!tick && k < 40) begin
            step();
            k++;
        end
        n_cmp++;
        if (!tick) begin
            n_err++;
            $display("FAIL %s: tick got 0 expected 1 within %0d cycles", nm, k);
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int h;
        int k;
        int saved;

        step();
        step();
        chk("rst_busy", int'(busy), 0);
        chk("rst_remain", int'(remain), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_evt_valid", int'(evt_valid), 0);
        chk("rst_evt_ch", int'(evt_ch), 0);
        reset = 1'b0;

        // 1: idle timebase, tick before edges 9, 19, 29
        for (int n = 0; n < 30; n++) begin
            chk("t1_tick", int'(tick), ((n % 10) == 9) ? 1 : 0);
            chk("t1_busy", int'(busy), 0);
            chk("t1_evt_valid", int'(evt_valid), 0);
            step();
        end

        // 2: ch0 dur=3
        exp_q.push_back(0);
        set_dur(0, 3);
        start = 4'b0001;
        step();
        start = 4'b0000;
        chk("t2_busy0", int'(busy[0]), 1);
        chk("t2_rem3", rem(0), 3);
        wait_tick_edge("t2_tick_a");
        chk("t2_rem2", rem(0), 2);
        wait_tick_edge("t2_tick_b");
        chk("t2_rem1", rem(0), 1);
        wait_tick_edge("t2_tick_c");
        chk("t2_rem0", rem(0), 0);
        chk("t2_valid_not_yet", int'(evt_valid), 0);
        step();
        chk("t2_valid", int'(evt_valid), 1);
        chk("t2_ch", int'(evt_ch), 0);
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        chk("t2_busy0_clear", int'(busy[0]), 0);
        chk("t2_valid_clear", int'(evt_valid), 0);

        // 3: ch1+ch2 together, stalled consumer, then back-to-back
        exp_q.push_back(1);
        exp_q.push_back(2);
        set_dur(1, 2);
        set_dur(2, 2);
        start = 4'b0110;
        step();
        start = 4'b0000;
        chk("t3_busy", int'(busy), 6);
        wait_tick_edge("t3_tick_a");
        wait_tick_edge("t3_tick_b");
        step();
        chk("t3_valid", int'(evt_valid), 1);
        chk("t3_ch1", int'(evt_ch), 1);
        for (int n = 0; n < 5; n++) step();
        chk("t3_ch1_stable", int'(evt_ch), 1);
        evt_ready = 1'b1;
        step();
        chk("t3_b2b_valid", int'(evt_valid), 1);
        chk("t3_b2b_ch2", int'(evt_ch), 2);
        chk("t3_busy1_clear", int'(busy[1]), 0);
        step();
        evt_ready = 1'b0;
        chk("t3_valid_clear", int'(evt_valid), 0);
        chk("t3_busy_clear", int'(busy), 0);

        // 4: dur=0 on ch3, then start+cancel on running ch0
        exp_q.push_back(3);
        set_dur(3, 0);
        start = 4'b1000;
        step();
        start = 4'b0000;
        chk("t4_busy3", int'(busy[3]), 1);
        chk("t4_valid_not_yet", int'(evt_valid), 0);
        step();
        chk("t4_valid", int'(evt_valid), 1);
        chk("t4_ch3", int'(evt_ch), 3);
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        chk("t4_busy3_clear", int'(busy[3]), 0);
        set_dur(0, 5);
        start = 4'b0001;
        step();
        chk("t4_ch0_run", int'(busy[0]), 1);
        set_dur(0, 7);
        cancel = 4'b0001;
        step();
        start = 4'b0000;
        cancel = 4'b0000;
        chk("t4_cancel_busy0", int'(busy[0]), 0);
        chk("t4_cancel_rem0", rem(0), 0);
        step();
        chk("t4_no_event", int'(evt_valid), 0);

        // 5: locked channel ignores cancel/start; PEND ignores start
        exp_q.push_back(1);
        exp_q.push_back(2);
        set_dur(1, 0);
        set_dur(2, 0);
        start = 4'b0110;
        step();
        start = 4'b0000;
        step();
        chk("t5_valid", int'(evt_valid), 1);
        chk("t5_ch1", int'(evt_ch), 1);
        set_dur(1, 9);
        set_dur(2, 9);
        cancel = 4'b0010;
        start = 4'b0110;
        step();
        cancel = 4'b0000;
        start = 4'b0000;
        chk("t5_locked_busy1", int'(busy[1]), 1);
        chk("t5_locked_rem1", rem(1), 0);
        chk("t5_pend_rem2", rem(2), 0);
        chk("t5_pend_busy2", int'(busy[2]), 1);
        chk("t5_still_ch1", int'(evt_ch), 1);
        evt_ready = 1'b1;
        step();
        chk("t5_b2b_ch2", int'(evt_ch), 2);
        step();
        evt_ready = 1'b0;
        chk("t5_all_idle", int'(busy), 0);
        chk("t5_valid_clear", int'(evt_valid), 0);

`ifdef TIMER_PAUSE_EN
        // 6: pause freezes the timebase mid-run
        set_dur(0, 5);
        start = 4'b0001;
        step();
        start = 4'b0000;
        wait_tick_edge("t6_tick_a");
        chk("t6_rem4", rem(0), 4);
        step();
        step();
        step();
        pause = 1'b1;
        h = mcnt;
        saved = rem(0);
        for (int n = 0; n < 25; n++) begin
            chk("t6_pause_tick", int'(tick), 0);
            step();
        end
        chk("t6_pause_rem", rem(0), saved);
        pause = 1'b0;
        k = 0;
        while (!tick && k < 20) begin
            step();
            k++;
        end
        chk("t6_resume_delay", k, 9 - h);
        step();
        chk("t6_rem_after", rem(0), saved - 1);
        cancel = 4'b0001;
        step();
        cancel = 4'b0000;
        chk("t6_cancel", int'(busy[0]), 0);
`endif

        for (int n = 0; n < 5; n++) step();
        chk("evt_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tick_timer_scheduler.md
# tick_timer_scheduler

Multi-channel timer scheduler on a shared timebase. One internal prescaler turns the 100 MHz system clock into a single-cycle `tick` enable. Up to NCH requesters each run an independent countdown in ticks on that enable. A round-robin arbiter serializes the expiry events onto one valid/ready port. It sits between the system clock and the game/display control logic, and replaces per-feature derived clocks with one clock-enable timebase.

## Interface
- CLK_HZ, 100_000_000, input clock frequency
- TICK_HZ, 1, tick rate; DIV = CLK_HZ/TICK_HZ, integer, ≥2
- NCH, 4, number of timer channels, ≥2
- DUR_W, 8, duration/remaining width in ticks
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- start  in  NCH  per-channel load/restart strobe
- dur  in  NCH*DUR_W  per-channel duration; slice i belongs to channel i
- cancel  in  NCH  per-channel abort strobe
- busy  out  NCH  channel not IDLE
- remain  out  NCH*DUR_W  per-channel remaining ticks
- tick  out  1  one-cycle pulse every DIV cycles
- evt_valid  out  1  expiry event presented
- evt_ch  out  $clog2(NCH)  expired channel index
- evt_ready  in  1  consumer accepts event
- pause  in  1  freeze timebase (TIMER_PAUSE_EN only)

## Operation
- **Prescaler:** counter of width $clog2(DIV) runs 0..DIV-1, then wraps to 0. `tick` is 1 in the cycle the count equals DIV-1.
- **Channel states:** IDLE, RUN, PEND.
  - **IDLE + start:** load remain=dur. Go to RUN, or to PEND if dur==0.
  - **RUN + tick:** if remain==1, set remain=0 and go to PEND; otherwise decrement remain.
  - **RUN + start:** reload remain=dur. Start beats a same-cycle tick.
  - **PEND + start:** ignored. The pending event must drain first.
  - **cancel in RUN or PEND:** go to IDLE with remain=0. Cancel beats a same-cycle start.
  - **Locked channel:** the channel currently shown on evt_ch ignores both cancel and start until its handshake.
- **Arbiter:** round-robin over PEND channels that are not yet presented. Search starts at ptr.
  - Winner is registered into evt_ch, and evt_valid is set.
  - evt_valid and evt_ch stay stable until evt_valid&evt_ready.
  - On handshake, the channel goes to IDLE and ptr becomes evt_ch+1 mod NCH.
  - A new winner may be registered in the same handshake cycle, giving back-to-back events.
- **Outputs:** busy[i] = state!=IDLE. remain is a registered output.

## Timing
- **Reset values:** all outputs 0. Prescaler=0, ptr=0, all channels IDLE.
- **First tick:** `tick` first asserts in cycle DIV-1 after reset release (cycle 0 = first edge with reset low). After that it asserts every DIV cycles.
- **Start latency:** start at edge n gives busy=1 and remain=dur after edge n.
- **Expiry latency:** PEND is entered at the tick edge. evt_valid asserts one edge later if the output is free.
- **dur==0:** evt_valid asserts 2 edges after start.
- **Handshake:** the channel is IDLE after the handshake edge. It can be restarted the next cycle.
- **Simultaneous expiries:** several channels expiring on the same tick are presented in round-robin order from ptr, one per handshake.
- **Reset mid-operation:** all state is cleared immediately (asynchronous). No events are lost-tracked.

## Configuration
- **TIMER_PAUSE_EN defined:**
  - `pause` port exists.
  - pause=1 holds the prescaler and suppresses `tick`, so RUN counters freeze.
  - start, cancel and the event handshake still operate.
  - On release, counting resumes from the held prescaler value.
- **TIMER_PAUSE_EN undefined:** no `pause` port. The timebase runs continuously.

## Structure
- **Package timer_pkg:**
  - ch_state_t enum {IDLE, RUN, PEND}
  - default CLK_HZ
  - DIV derivation function
- **Sub-module rr_arbiter:**
  - parameter N
  - inputs req[N] and ptr
  - outputs grant index and any
  - purely combinational
  - instantiated once; registering stays in the parent

## Test plan
Bench parameters: CLK_HZ=10, TICK_HZ=1 (DIV=10), NCH=4, DUR_W=8.
1. Reset release, no stimulus → tick at cycles 9, 19, 29; busy=0, evt_valid=0 throughout.
2. start[0] with dur=3 → remain0 goes 3,2,1,0 on successive ticks. evt_valid=1 with evt_ch=0 one edge after the third tick. evt_ready=1 → busy0=0 next cycle.
3. ch1 and ch2 start same cycle, dur=2, evt_ready held 0 for 5 cycles → evt_ch=1 stays stable. On ready, ch1 handshake, then ch2 presented back-to-back.
4. start[3] with dur=0 → evt_valid/evt_ch=3 two edges later, with no tick involved. start+cancel on a running ch0 in the same cycle → ch0 IDLE, remain=0.
5. cancel[1] while ch1 is being presented → ignored; the event completes on handshake. start[2] during PEND → ignored.
6. TIMER_PAUSE_EN defined: pause=1 for 25 cycles during a dur=5 run → no tick, remain unchanged; after release, the next tick arrives after the remaining prescaler count.
